// File: rtl/dbus_wait_responder.sv
// DBus slave: word-addressed on-chip RAM with a programmable number of wait states.
// Optional macro DBUS_RESP_POSTED_WR_EN: stores bypass the wait states and complete at once.
module dbus_wait_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Req,
  input  logic        i_Sel,
  input  logic        i_WrEn,
  input  logic [31:0] i_Addr,
  input  logic [3:0]  i_ByteEn,
  input  logic [31:0] i_WrData,
  output logic        o_Gnt,
  output logic        o_WaitReq,
  output logic [31:0] o_RdData,
  output logic        o_RdValid,
  output logic        o_Err
);

  if (WAIT_STATES > 15) begin : g_badWaitStates
    $error("dbus_wait_responder: WAIT_STATES must be in 0..15");
  end

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, nextState;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic                  reqWr, reqErr;
  logic [ADDR_WIDTH-1:0] reqIdx;
  logic [3:0]            reqBe;
  logic [31:0]           reqData;
  logic [31:0]           rdData;

  logic                  accept, direct, doOp;
  logic [31:0]           addrOff;
  logic [ADDR_WIDTH-1:0] inIdx;
  logic                  inErr;
  logic [3:0]            inWait;
  logic [1:0]            unusedAddrBits;

  logic                  opWr, opErr;
  logic [ADDR_WIDTH-1:0] opIdx;
  logic [3:0]            opBe;
  logic [31:0]           opData;

  assign o_Gnt     = i_Req & i_Sel;
  assign o_WaitReq = (state == S_WAIT);
  assign accept    = o_Gnt & ~o_WaitReq;

  // Addresses below the window wrap to a huge index and so are flagged as well.
  assign addrOff        = i_Addr - BASE_ADDR;
  assign inIdx          = addrOff[ADDR_WIDTH+1:2];
  assign inErr          = |addrOff[31:ADDR_WIDTH+2];
  assign unusedAddrBits = addrOff[1:0];

`ifdef DBUS_RESP_POSTED_WR_EN
  assign inWait = i_WrEn ? 4'd0 : WS;
`else
  assign inWait = WS;
`endif

  always_comb begin
    nextState = S_IDLE;
    direct    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (inWait == 4'd0) begin
            nextState = S_DONE;
            direct    = 1'b1;
          end else begin
            nextState = S_WAIT;
          end
        end
      end
      S_WAIT:  nextState = (cnt == 4'd1) ? S_DONE : S_WAIT;
      default: nextState = S_IDLE;
    endcase
  end

  // The RAM access happens on the edge that enters DONE; zero-latency accesses
  // take their operands straight from the bus since the request registers load on that same edge.
  // A load accepted during a store's DONE therefore always sees the committed word.
  assign opWr   = direct ? i_WrEn   : reqWr;
  assign opErr  = direct ? inErr    : reqErr;
  assign opIdx  = direct ? inIdx    : reqIdx;
  assign opBe   = direct ? i_ByteEn : reqBe;
  assign opData = direct ? i_WrData : reqData;
  assign doOp   = (nextState == S_DONE) & ~i_Rst;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      reqWr   <= 1'b0;
      reqErr  <= 1'b0;
      reqIdx  <= '0;
      reqBe   <= '0;
      reqData <= '0;
      rdData  <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        reqWr   <= i_WrEn;
        reqErr  <= inErr;
        reqIdx  <= inIdx;
        reqBe   <= i_ByteEn;
        reqData <= i_WrData;
        cnt     <= inWait;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (doOp && !opWr) begin
        rdData <= opErr ? '0 : mem[opIdx];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (doOp && opWr && !opErr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (opBe[b]) mem[opIdx][8*b +: 8] <= opData[8*b +: 8];
      end
    end
  end

  assign o_RdData  = rdData;
  assign o_RdValid = (state == S_DONE) & ~reqWr;
  assign o_Err     = (state == S_DONE) & reqErr;

endmodule

// File: tb/tb_dbus_wait_responder.sv
// Randomized bench for dbus_wait_responder against a transaction-level memory model.
module tb_dbus_wait_responder;

  localparam int unsigned AW   = 10;
  localparam int unsigned WS   = 2;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int unsigned NW   = 16;

  logic        clk = 1'b0;
  logic        rst, req, sel, wrEn;
  logic [31:0] addr, wrData;
  logic [3:0]  be;
  logic        gnt, waitReq, rdValid, err;
  logic [31:0] rdData;

  logic        zReq, zWrEn;
  logic [31:0] zAddr, zWrData;
  logic [3:0]  zBe;
  logic        zGnt, zWaitReq, zRdValid, zErr;
  logic [31:0] zRdData;

  always #5 clk = ~clk;

  dbus_wait_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS), .BASE_ADDR(BASE)) u_dut (
    .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_Sel(sel), .i_WrEn(wrEn),
    .i_Addr(addr), .i_ByteEn(be), .i_WrData(wrData),
    .o_Gnt(gnt), .o_WaitReq(waitReq), .o_RdData(rdData),
    .o_RdValid(rdValid), .o_Err(err)
  );

  dbus_wait_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dutZero (
    .i_Clk(clk), .i_Rst(rst), .i_Req(zReq), .i_Sel(1'b1), .i_WrEn(zWrEn),
    .i_Addr(zAddr), .i_ByteEn(zBe), .i_WrData(zWrData),
    .o_Gnt(zGnt), .o_WaitReq(zWaitReq), .o_RdData(zRdData),
    .o_RdValid(zRdValid), .o_Err(zErr)
  );

  logic [31:0] model [NW];
  logic [31:0] lastRd;
  int nChecks = 0;
  int nPass   = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int unsigned latency(input bit wr);
`ifdef DBUS_RESP_POSTED_WR_EN
    return wr ? 0 : WS;
`else
    return WS;
`endif
  endfunction

  // Called at a negedge with the DUT idle or in DONE; returns at the DONE negedge.
  task automatic doAccess(input bit wr, input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, input bit dropMid);
    logic [31:0] off, expRd;
    bit          isErr;
    int unsigned lat;
    checkEq("notWaitingAtPresent", waitReq, 0);
    req = 1'b1; sel = 1'b1; wrEn = wr; addr = a; be = b; wrData = d;
    #1 checkEq("gnt", gnt, 1);
    @(posedge clk);
    lat = latency(wr);
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clk);
      checkEq("waitReqHigh", waitReq, 1);
      checkEq("rdValidInWait", rdValid, 0);
      checkEq("errInWait", err, 0);
      if (req) checkEq("gntHeld", gnt, 1);
      if (c == 1 && dropMid) req = 1'b0;
    end
    @(negedge clk);
    off   = a - BASE;
    isErr = (off >> 2) >= (32'd1 << AW);
    checkEq("waitReqDone", waitReq, 0);
    checkEq("rdValidDone", rdValid, !wr);
    checkEq("errDone", err, isErr);
    if (!wr) begin
      expRd  = isErr ? 32'h0 : model[off[5:2]];
      lastRd = expRd;
    end else if (!isErr) begin
      for (int k = 0; k < 4; k++)
        if (b[k]) model[off[5:2]][8*k +: 8] = d[8*k +: 8];
    end
    checkEq("rdData", rdData, lastRd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'($urandom); sel = 1'b0;
      #1 checkEq("gntUnselected", gnt, 0);
      @(negedge clk);
      checkEq("waitReqIdle", waitReq, 0);
      checkEq("rdValidIdle", rdValid, 0);
      checkEq("errIdle", err, 0);
      checkEq("rdDataHold", rdData, lastRd);
    end
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    bit          rw;
    int unsigned k, idx;
    rst = 1'b1; req = 1'b0; sel = 1'b0; wrEn = 1'b0; addr = '0; be = '0; wrData = '0;
    zReq = 1'b0; zWrEn = 1'b0; zAddr = '0; zBe = '0; zWrData = '0;
    lastRd = '0;
    repeat (2) @(negedge clk);
    checkEq("rstWaitReq", waitReq, 0);
    checkEq("rstRdValid", rdValid, 0);
    checkEq("rstErr", err, 0);
    checkEq("rstRdData", rdData, 0);
    rst = 1'b0;

    // zero-wait instance: store then back-to-back load, both complete one cycle after acceptance
    zReq = 1'b1; zWrEn = 1'b1; zAddr = BASE + 32'd8; zBe = 4'hF; zWrData = 32'h1234_5678;
    @(negedge clk);
    checkEq("zStoreWait", zWaitReq, 0);
    checkEq("zStoreRdValid", zRdValid, 0);
    zWrEn = 1'b0;
    @(negedge clk);
    checkEq("zLoadWait", zWaitReq, 0);
    checkEq("zLoadRdValid", zRdValid, 1);
    checkEq("zLoadData", zRdData, 32'h1234_5678);
    zReq = 1'b0;
    @(negedge clk);
    checkEq("zIdleRdValid", zRdValid, 0);

    for (int i = 0; i < int'(NW); i++) begin
      d = (i == 5) ? 32'hDEAD_BEEF : (i == 3) ? 32'h1122_3344 : (i == 7) ? 32'h0 : $urandom;
      doAccess(1'b1, BASE + 32'(4 * i), 4'hF, d, 1'b0);
    end
    idle(2);

    doAccess(1'b0, 32'h0001_0014, 4'h0, 32'h0, 1'b0);
    checkEq("loadWord5", rdData, 32'hDEAD_BEEF);
    idle(1);
    doAccess(1'b1, BASE + 32'd12, 4'b0101, 32'hAABB_CCDD, 1'b0);
    idle(1);
    doAccess(1'b0, BASE + 32'd12, 4'h0, 32'h0, 1'b0);
    checkEq("byteMerge", rdData, 32'h11BB_33DD);

    doAccess(1'b0, BASE + 32'd4, 4'h0, 32'h0, 1'b0);
    doAccess(1'b0, BASE + 32'd8, 4'h0, 32'h0, 1'b0);
    idle(1);

    doAccess(1'b0, BASE + 32'(4 * (1 << AW)), 4'h0, 32'h0, 1'b0);
    checkEq("oorLoadZero", rdData, 32'h0);
    doAccess(1'b1, BASE + 32'(4 * (1 << AW)), 4'hF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < int'(NW); i++) doAccess(1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, 1'b0);
    idle(1);

`ifdef DBUS_RESP_POSTED_WR_EN
    rw = 1'b0;
`else
    rw = 1'b1;
`endif
    req = 1'b1; sel = 1'b1; wrEn = rw; addr = BASE + 32'd28; be = 4'hF; wrData = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    checkEq("preRstWait", waitReq, 1);
    rst = 1'b1;
    #1 checkEq("asyncRstWait", waitReq, 0);
    checkEq("asyncRstRdValid", rdValid, 0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lastRd = 32'h0;
    checkEq("postRstRdData", rdData, 0);
    idle(1);
    doAccess(1'b0, BASE + 32'd28, 4'h0, 32'h0, 1'b0);
    checkEq("word7Untouched", rdData, 32'h0);

    for (int t = 0; t < 150; t++) begin
      k   = $urandom_range(0, 9);
      idx = $urandom_range(0, NW - 1);
      if (k == 0)      a = BASE - 32'(4 * (idx + 1));
      else if (k == 1) a = BASE + 32'(4 * ((1 << AW) + idx));
      else             a = BASE + 32'(4 * idx);
      a = a + 32'($urandom_range(0, 3));
      doAccess(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3) == 0);
      k = $urandom_range(0, 2);
      if (k != 0) idle(int'(k));
    end
    for (int i = 0; i < int'(NW); i++) doAccess(1'b0, BASE + 32'(4 * i), 4'h0, 32'h0, 1'b0);
    idle(2);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
